capture_fifo_serializer: RTL

//  Single-clock capture buffer for multi-lane ADC sample words. On Arm it captures
//  a programmable number of LANES*LANE_W-bit words, then serialises them one lane
//  (byte) at a time toward the host link. Sits between the ADC deserialiser and the

---
 rtl/capture_fifo_pkg.sv | 18 +
 rtl/sdp_ram_sync.sv | 26 ++
 rtl/capture_fifo_serializer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/capture_fifo_pkg.sv
// Shared encodings and helpers for the capture FIFO serializer.
package capture_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] HDR_SYNC  = 8'hA5;
    localparam int         HDR_LANES = 2;

    // A zero or oversized request captures the whole buffer.
    function automatic int eff_len(input int len, input int depth);
        return (len == 0 || len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/sdp_ram_sync.sv
// Simple dual-port RAM with a registered read port; a read of the address being
// written in the same cycle returns the new data.
module sdp_ram_sync #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/capture_fifo_serializer.sv
// Arm-triggered capture of LANES*LANE_W sample words, drained one lane per read, MSB lane first.
// Define CAPTURE_FIFO_HEADER_EN to prefix each drain with {8'hA5, word count} (LANE_W must be 8).
module capture_fifo_serializer
    import capture_fifo_pkg::*;
#(
    parameter  int LANES  = 4,
    parameter  int LANE_W = 8,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [LANES*LANE_W-1:0] i_data_in,
    input  logic                    i_write_strobe,
    input  logic                    i_arm,
    input  logic [ADDR_W:0]         i_capture_length,
    input  logic                    i_read_enable,
    output logic [LANE_W-1:0]       o_data_out,
    output logic                    o_data_valid,
    output logic                    o_fifo_not_full,
    output logic                    o_data_ready_to_send,
    output logic [1:0]              o_state,
    output logic                    o_overflow
);

    localparam int                 LANE_IW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_IW-1:0] LAST_LANE = LANE_IW'(LANES - 1);

    state_e                       r_state, w_state_next;
    logic [ADDR_W:0]              r_len, r_wr_cnt, r_word, w_eff_len;
    logic [LANE_IW-1:0]           r_lane, w_sel;
    logic [LANE_W-1:0]            r_data_out, w_hdr_lane;
    logic                         r_data_valid, r_overflow, r_armed;
    logic                         w_we, w_wr_last, w_accept, w_in_hdr, w_word_end, w_last;
    logic [ADDR_W-1:0]            w_raddr;
    logic [LANES*LANE_W-1:0]      w_rd_data;
    logic [LANES-1:0][LANE_W-1:0] w_rd_word;

    assign w_eff_len  = (ADDR_W+1)'(eff_len(int'(i_capture_length), DEPTH));
    assign w_we       = o_fifo_not_full && i_write_strobe;
    assign w_wr_last  = w_we && ((r_wr_cnt + 1'b1) == r_len);
    assign w_accept   = o_data_ready_to_send && i_read_enable;
    assign w_word_end = w_accept && !w_in_hdr && (r_lane == LAST_LANE);
    assign w_last     = w_word_end && (r_word == (r_len - 1'b1));
    assign w_sel      = LAST_LANE - r_lane;
    assign w_rd_word  = w_rd_data;

    // Address always points at the word the next lane comes from, so the registered
    // RAM output already holds it by the time that lane is requested.
    assign w_raddr = w_word_end ? ADDR_W'(r_word + 1'b1) : r_word[ADDR_W-1:0];

    sdp_ram_sync #(.WIDTH(LANES*LANE_W), .DEPTH(DEPTH)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_cnt[ADDR_W-1:0]),
        .i_wdata (i_data_in),
        .i_raddr (w_raddr),
        .o_rdata (w_rd_data)
    );

`ifdef CAPTURE_FIFO_HEADER_EN
    logic [1:0] r_hdr;

    assign w_in_hdr   = (r_hdr < 2'(HDR_LANES));
    assign w_hdr_lane = (r_hdr == 2'd0) ? LANE_W'(HDR_SYNC) : LANE_W'(r_len);

    always_ff @(posedge i_clk) begin
        if (i_reset)                          r_hdr <= '0;
        else if (r_state == ST_IDLE && i_arm) r_hdr <= '0;
        else if (w_accept && w_in_hdr)        r_hdr <= r_hdr + 1'b1;
    end
`else
    assign w_in_hdr   = 1'b0;
    assign w_hdr_lane = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_arm)     w_state_next = ST_FILL;
            ST_FILL:  if (w_wr_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_last)    w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_state              = r_state;
        o_fifo_not_full      = (r_state == ST_FILL) && (r_wr_cnt < r_len);
        o_data_ready_to_send = (r_state == ST_DRAIN);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len        <= '0;
            r_wr_cnt     <= '0;
            r_word       <= '0;
            r_lane       <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_data_valid <= w_accept;
            if (r_state == ST_IDLE && i_arm) begin
                r_len      <= w_eff_len;
                r_wr_cnt   <= '0;
                r_word     <= '0;
                r_lane     <= '0;
                r_overflow <= 1'b0;
                r_armed    <= 1'b1;
            end else begin
                if (i_write_strobe && r_armed && r_state != ST_FILL) r_overflow <= 1'b1;
                if (w_we) r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_accept) begin
                    r_data_out <= w_in_hdr ? w_hdr_lane : w_rd_word[w_sel];
                    if (!w_in_hdr) begin
                        r_lane <= w_word_end ? '0 : r_lane + 1'b1;
                        if (w_word_end) r_word <= r_word + 1'b1;
                    end
                end
            end
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_overflow   = r_overflow;

endmodule
